// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
//   Radix-2 restoring divider. It produces one quotient bit per clock and
//   supports signed and unsigned quotient and remainder.
//
//   Parameters
//     WIDTH        operand/result width in bits (4..64)
//     OP_DIV       op code for signed quotient     (default 2'b00)
//     OP_DIVU      op code for unsigned quotient   (default 2'b01)
//     OP_REM       op code for signed remainder    (default 2'b10)
//     OP_REMU      op code for unsigned remainder  (default 2'b11)
//
//   Ports
//     clk          single clock; all logic on its rising edge
//     rst          synchronous, active-high reset
//     a            dividend
//     b            divisor
//     op           operation select
//     enabled      request level
//     c            registered result (quotient or remainder)
//     completed    registered; high while c is valid for the current request
//     busy         registered; high while iterating (state CALC)
//     o_dbg_state  current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
//   Request protocol
//     The requester raises enabled together with valid a/b/op and keeps it
//     high. The operands are captured on the first edge that samples enabled
//     high in IDLE; later changes are ignored. completed rises when c is valid
//     and stays high, with c held, for as long as enabled stays high. Any edge
//     that samples enabled low aborts or ends the request and returns to IDLE;
//     c keeps its last value. A new request needs at least one low cycle on
//     enabled.
// -----------------------------------------------------------------------------
module iterative_divider #(
  parameter int         WIDTH   = 32,
  parameter logic [1:0] OP_DIV  = 2'b00,
  parameter logic [1:0] OP_DIVU = 2'b01,
  parameter logic [1:0] OP_REM  = 2'b10,
  parameter logic [1:0] OP_REMU = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             enabled,
  output logic [WIDTH-1:0] c,
  output logic             completed,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] LP_CNT_INIT = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] LP_CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] LP_SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;     // dividend magnitude shifting out, quotient in
  logic [WIDTH-1:0] r_rem;     // partial remainder (always < divisor)
  logic [WIDTH-1:0] r_div;     // divisor magnitude
  logic             r_is_rem;  // result select: remainder instead of quotient
  logic             r_neg_q;   // quotient must be negated in FIX
  logic             r_neg_r;   // remainder must be negated in FIX
  logic [WIDTH-1:0] r_c;
  logic             r_completed;
  logic             r_busy;

  // Request decode, evaluated on the capture edge only.
  logic             w_is_div;
  logic             w_is_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic             w_ovf;

  assign w_is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign w_is_signed = (op == OP_DIV) || (op == OP_REM);
  assign w_a_neg     = w_is_signed && a[WIDTH-1];
  assign w_b_neg     = w_is_signed && b[WIDTH-1];
  // The magnitude of the signed minimum is 2^(WIDTH-1). Its negation wraps to
  // the same bit pattern, which reads correctly as an unsigned magnitude.
  assign w_a_mag     = w_a_neg ? (~a + LP_CNT_ONE) : a;
  assign w_b_mag     = w_b_neg ? (~b + LP_CNT_ONE) : b;
  assign w_b_zero    = (b == '0);
  assign w_ovf       = w_is_signed && (a == LP_SMIN) && (b == '1);

  // One restoring step. The shifted remainder needs WIDTH+1 bits because it
  // can reach 2*divisor-1. The sign of the trial difference decides the
  // quotient bit.
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_is_rem    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_c         <= '0;
      r_completed <= 1'b0;
      r_busy      <= 1'b0;
    end else if (!enabled) begin
      // Abort or end of request: c keeps its last value.
      r_state     <= S_IDLE;
      r_completed <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_is_rem    <= !w_is_div;
          r_completed <= 1'b0;
          if (w_b_zero || w_ovf) begin
            // The special results are preloaded as an already-finished
            // quotient/remainder pair with no sign fix-up. Passing through FIX
            // then produces them one edge after capture.
            r_quo   <= w_b_zero ? '1 : a;
            r_rem   <= w_b_zero ? a : '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_FIX;
          end else begin
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_div   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= LP_CNT_INIT;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end

        S_CALC: begin
          if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - LP_CNT_ONE;
          if (r_cnt == LP_CNT_ONE) begin
            r_busy  <= 1'b0;
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (r_is_rem) begin
            r_c <= r_neg_r ? (~r_rem + LP_CNT_ONE) : r_rem;
          end else begin
            r_c <= r_neg_q ? (~r_quo + LP_CNT_ONE) : r_quo;
          end
          r_completed <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          // Hold the result until the requester drops enabled.
          r_completed <= 1'b1;
          r_state     <= S_DONE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_completed <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign c           = r_c;
  assign completed   = r_completed;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iterative_divider.sv
// -----------------------------------------------------------------------------
// tb_iterative_divider
//   Testbench for iterative_divider at WIDTH=32 and WIDTH=8. It covers
//   directed cases, completion latency, result hold, abort, reset while
//   busy, and random operands checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_iterative_divider;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a32, b32, c32;
  logic [1:0]  op32, dbg32;
  logic        en32, done32, busy32;

  logic [7:0]  a8, b8, c8;
  logic [1:0]  op8, dbg8;
  logic        en8, done8, busy8;

  iterative_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .op(op32), .enabled(en32),
    .c(c32), .completed(done32), .busy(busy32), .o_dbg_state(dbg32)
  );

  iterative_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .op(op8), .enabled(en8),
    .c(c8), .completed(done8), .busy(busy8), .o_dbg_state(dbg8)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_div(input int w, input logic [63:0] ra,
                                          input logic [63:0] rb, input logic [1:0] rop);
    logic [63:0] mask, ua, ub, res;
    longint sa, sb, smin;
    mask = (64'd1 << w) - 64'd1;
    ua   = ra & mask;
    ub   = rb & mask;
    sa   = longint'(ua << (64 - w));
    sa   = sa >>> (64 - w);
    sb   = longint'(ub << (64 - w));
    sb   = sb >>> (64 - w);
    smin = -(longint'(1) << (w - 1));
    case (rop)
      OP_DIVU: res = (ub == 0) ? mask : ua / ub;
      OP_REMU: res = (ub == 0) ? ua : ua % ub;
      OP_DIV: begin
        if (sb == 0)                     res = mask;
        else if (sa == smin && sb == -1) res = ua;
        else                             res = 64'(sa / sb);
      end
      default: begin
        if (sb == 0)                     res = ua;
        else if (sa == smin && sb == -1) res = 64'd0;
        else                             res = 64'(sa % sb);
      end
    endcase
    return res & mask;
  endfunction

  function automatic bit is_special(input int w, input logic [63:0] ra,
                                    input logic [63:0] rb, input logic [1:0] rop);
    logic [63:0] mask, smin_pat;
    mask     = (64'd1 << w) - 64'd1;
    smin_pat = 64'd1 << (w - 1);
    if ((rb & mask) == 0) return 1'b1;
    if ((rop == OP_DIV || rop == OP_REM) && (ra & mask) == smin_pat && (rb & mask) == mask)
      return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  // lat counts edges from the capture edge (n=1) to the first edge after
  // which completed reads high; -1 means the cycle budget ran out.
  task automatic do_op32(input logic [31:0] ta, input logic [31:0] tb_, input logic [1:0] top,
                         input bit scramble, output logic [31:0] rc, output int lat);
    @(negedge clk);
    a32 = ta; b32 = tb_; op32 = top; en32 = 1'b1;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done32) begin lat = n; break; end
      if (scramble) begin
        a32 = $urandom; b32 = $urandom; op32 = 2'($urandom_range(0, 3));
      end
    end
    rc = c32;
  endtask

  task automatic release32();
    @(negedge clk);
    en32 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top,
                        input bit scramble, output logic [7:0] rc, output int lat);
    @(negedge clk);
    a8 = ta; b8 = tb_; op8 = top; en8 = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done8) begin lat = n; break; end
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom_range(0, 3));
      end
    end
    rc = c8;
  endtask

  task automatic release8();
    @(negedge clk);
    en8 = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // enabled is held high during reset to show that reset wins.
    rst = 1'b1; en32 = 1'b1; a32 = 32'd100; b32 = 32'd7; op32 = OP_DIVU;
    en8 = 1'b0; a8 = '0; b8 = '0; op8 = OP_DIVU;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (c32 !== 32'd0) begin failures++; $display("FAIL reset_c32: got %0h expected 0", c32); end
    checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL reset_completed32: got %b expected 0", done32); end
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy32: got %b expected 0", busy32); end
    checks++; if (dbg32 !== 2'd0) begin failures++; $display("FAIL reset_state32: got %0d expected 0", dbg32); end
    checks++; if (c8 !== 8'd0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++; $display("FAIL reset_dut8: got c=%0h done=%b busy=%b expected 0/0/0", c8, done8, busy8);
    end
    @(negedge clk);
    en32 = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    logic [31:0] rc;
    int lat;
    v[0] = '{32'd100,        32'd7,          OP_DIVU, 32'd14,         34};
    v[1] = '{32'd100,        32'd7,          OP_REMU, 32'd2,          34};
    v[2] = '{32'hFFFF_FFF9,  32'd2,          OP_DIV,  32'hFFFF_FFFD,  34};
    v[3] = '{32'hFFFF_FFF9,  32'd2,          OP_REM,  32'hFFFF_FFFF,  34};
    v[4] = '{32'd5,          32'd0,          OP_DIVU, 32'hFFFF_FFFF,  2};
    v[5] = '{32'd5,          32'd0,          OP_REMU, 32'd5,          2};
    v[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  OP_DIV,  32'h8000_0000,  2};
    v[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  OP_REM,  32'd0,          2};
    v[8] = '{32'd5,          32'd0,          OP_DIV,  32'hFFFF_FFFF,  2};
    v[9] = '{32'hFFFF_FFF9,  32'd0,          OP_REM,  32'hFFFF_FFF9,  2};
    for (int i = 0; i < 10; i++) begin
      do_op32(v[i].a, v[i].b, v[i].op, 1'b0, rc, lat);
      checks++;
      if (rc !== v[i].exp) begin
        failures++; $display("FAIL directed_c[%0d]: got %0h expected %0h", i, rc, v[i].exp);
      end
      checks++;
      if (lat !== v[i].lat) begin
        failures++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
      end
      release32();
    end
  endtask

  task automatic test_hold();
    logic [31:0] rc;
    int lat;
    do_op32(32'd1000, 32'd10, OP_DIVU, 1'b0, rc, lat);
    checks++; if (rc !== 32'd100) begin failures++; $display("FAIL hold_first: got %0d expected 100", rc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a32 = $urandom; b32 = $urandom; op32 = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      checks++;
      if (done32 !== 1'b1 || c32 !== 32'd100 || busy32 !== 1'b0) begin
        failures++; $display("FAIL hold_done: got c=%0d done=%b busy=%b expected 100/1/0", c32, done32, busy32);
      end
    end
    release32();
    checks++;
    if (done32 !== 1'b0 || c32 !== 32'd100) begin
      failures++; $display("FAIL hold_release: got c=%0d done=%b expected 100/0", c32, done32);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rc;
    int lat;
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; op32 = OP_DIVU; en32 = 1'b1;
    @(posedge clk);               // capture edge
    repeat (10) @(posedge clk);   // tenth CALC cycle
    #1;
    checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL abort_busy_before: got %b expected 1", busy32); end
    @(negedge clk);
    en32 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done32 !== 1'b0 || busy32 !== 1'b0) begin
      failures++; $display("FAIL abort_flags: got done=%b busy=%b expected 0/0", done32, busy32);
    end
    checks++; if (c32 !== 32'd100) begin failures++; $display("FAIL abort_c_retained: got %0d expected 100", c32); end
    do_op32(32'd9, 32'd3, OP_DIVU, 1'b0, rc, lat);
    checks++; if (rc !== 32'd3) begin failures++; $display("FAIL abort_rerun_c: got %0d expected 3", rc); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL abort_rerun_latency: got %0d expected 34", lat); end
    release32();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; op32 = OP_DIVU; en32 = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; a32 = 32'd1000; b32 = 32'd10;
    @(posedge clk); #1;
    checks++;
    if (c32 !== 32'd0 || done32 !== 1'b0 || busy32 !== 1'b0) begin
      failures++; $display("FAIL rstmid_state: got c=%0h done=%b busy=%b expected 0/0/0", c32, done32, busy32);
    end
    @(negedge clk);
    rst = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done32) begin lat = n; break; end
    end
    checks++; if (c32 !== 32'd100) begin failures++; $display("FAIL rstmid_c: got %0d expected 100", c32); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL rstmid_latency: got %0d expected 34", lat); end
    release32();
  endtask

  task automatic test_random32(input int n_ops);
    logic [31:0] ta, tb_, rc;
    logic [1:0]  top;
    logic [63:0] exp;
    int lat, exp_lat;
    for (int i = 0; i < n_ops; i++) begin
      ta = $urandom; tb_ = $urandom; top = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: tb_ = 32'd0;
        1: begin ta = 32'h8000_0000; tb_ = 32'hFFFF_FFFF; end
        2: tb_ = 32'($urandom_range(1, 15));
        3: ta = 32'($urandom_range(0, 255));
        4: tb_ = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp_q.push_back(ref_div(32, 64'(ta), 64'(tb_), top));
      exp_lat = is_special(32, 64'(ta), 64'(tb_), top) ? 2 : 34;
      do_op32(ta, tb_, top, 1'b1, rc, lat);
      exp = exp_q.pop_front();
      checks++;
      if (rc !== exp[31:0]) begin
        failures++; $display("FAIL rand32_c: a=%0h b=%0h op=%0d got %0h expected %0h", ta, tb_, top, rc, exp[31:0]);
      end
      checks++;
      if (lat !== exp_lat) begin
        failures++; $display("FAIL rand32_latency: got %0d expected %0d", lat, exp_lat);
      end
      release32();
    end
  endtask

  task automatic test_random8(input int n_ops);
    logic [7:0]  ta, tb_, rc;
    logic [1:0]  top;
    logic [63:0] exp;
    int lat, exp_lat;
    for (int i = 0; i < n_ops; i++) begin
      ta = 8'($urandom); tb_ = 8'($urandom); top = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: tb_ = 8'd0;
        1: begin ta = 8'h80; tb_ = 8'hFF; end
        2: tb_ = 8'($urandom_range(1, 7));
        3: tb_ = 8'hFF;
        default: ;
      endcase
      exp_q.push_back(ref_div(8, 64'(ta), 64'(tb_), top));
      exp_lat = is_special(8, 64'(ta), 64'(tb_), top) ? 2 : 10;
      do_op8(ta, tb_, top, 1'b1, rc, lat);
      exp = exp_q.pop_front();
      checks++;
      if (rc !== exp[7:0]) begin
        failures++; $display("FAIL rand8_c: a=%0h b=%0h op=%0d got %0h expected %0h", ta, tb_, top, rc, exp[7:0]);
      end
      checks++;
      if (lat !== exp_lat) begin
        failures++; $display("FAIL rand8_latency: got %0d expected %0d", lat, exp_lat);
      end
      release8();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_abort();
    test_reset_mid();
    test_random32(800);
    test_random8(1500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
